// File: rtl/astro_led_pkg.sv
// Shared types and constants for the LED status sequencer: FSM states, colour codes
// and the default terminal-node threshold.
package astro_led_pkg;

    localparam int unsigned NODE_W           = 8;
    localparam int unsigned END_NODE_DEFAULT = 11;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_FAULT,
        SHOW_NODE_OK,
        SHOW_NODE_END,
        DONE
    } led_state_e;

    typedef enum logic [1:0] {
        OFF,
        RED,
        GREEN,
        BLUE
    } colour_e;

    // One RGB LED drive, active-high
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

endpackage

// File: rtl/led_status_sequencer_if.sv
// Event inputs and LED/busy outputs of the status sequencer.
interface led_status_sequencer_if;
    import astro_led_pkg::*;

    logic              fault_detect;
    logic              node_flag;
    logic [NODE_W-1:0] node;
    logic              run_done;
    logic              led1_R1, led1_G1, led1_B1;
    logic              led2_R2, led2_G2, led2_B2;
    logic              led3_R3, led3_G3, led3_B3;
    logic              busy;

    modport master (
        output fault_detect, node_flag, node, run_done,
        input  led1_R1, led1_G1, led1_B1,
        input  led2_R2, led2_G2, led2_B2,
        input  led3_R3, led3_G3, led3_B3,
        input  busy
    );

    modport slave (
        input  fault_detect, node_flag, node, run_done,
        output led1_R1, led1_G1, led1_B1,
        output led2_R2, led2_G2, led2_B2,
        output led3_R3, led3_G3, led3_B3,
        output busy
    );

endinterface

// File: rtl/led_timer.sv
// Display hold counter and fault blink generator; both restart on load.
module led_timer #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned BLINK_HALF  = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero_c,
    output logic blink_next_c
);

    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_next;
    logic               blink;

    assign zero_c = (hold_cnt == '0);

    // Hold saturates at zero; blink phase flips each time its counter wraps
    always_comb begin
        hold_next      = hold_cnt;
        blink_cnt_next = blink_cnt;
        blink_next_c   = blink;
        if (load) begin
            hold_next      = HOLD_W'(HOLD_CYCLES - 1);
            blink_cnt_next = BLINK_W'(BLINK_HALF - 1);
            blink_next_c   = 1'b1;
        end else begin
            if (hold_cnt != '0) begin
                hold_next = hold_cnt - HOLD_W'(1);
            end
            if (blink_cnt == '0) begin
                blink_cnt_next = BLINK_W'(BLINK_HALF - 1);
                blink_next_c   = ~blink;
            end else begin
                blink_cnt_next = blink_cnt - BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            hold_cnt  <= hold_next;
            blink_cnt <= blink_cnt_next;
            blink     <= blink_next_c;
        end
    end

endmodule

// File: rtl/led_status_sequencer.sv
// Shows fault / node / run-complete events on three RGB LEDs, one timed display at a
// time, with fixed-priority arbitration of pending events and fault preemption.
module led_status_sequencer
    import astro_led_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned BLINK_HALF  = 12_500_000,
    parameter int unsigned END_NODE    = END_NODE_DEFAULT
) (
    input logic                   clk_50M,
    input logic                   rst_n,
    led_status_sequencer_if.slave bus
);

    led_state_e        state, state_next;
    logic              armed;
    logic              fault_q, node_flag_q, run_done_q;
    logic              pend_fault, pend_done, pend_node;
    logic [NODE_W-1:0] node_q;
    logic              edge_fault, edge_node, edge_done;
    logic              grant_fault, grant_done, grant_node;
    logic              load, pick, node_end;
    logic              zero_c, blink_next_c;
    colour_e           colour;
    rgb_t              rgb_c, rgb_q;
    logic              busy_q;

    // Edges are suppressed on the first cycle after reset so held inputs are ignored
    assign edge_fault = armed & bus.fault_detect & ~fault_q;
    assign edge_node  = armed & bus.node_flag & ~node_flag_q;
    assign edge_done  = armed & bus.run_done & ~run_done_q;
    assign node_end   = (node_q >= NODE_W'(END_NODE));

    led_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .BLINK_HALF  (BLINK_HALF)
    ) u_timer (
        .clk          (clk_50M),
        .rst_n        (rst_n),
        .load         (load),
        .zero_c       (zero_c),
        .blink_next_c (blink_next_c)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fault preempts any show; otherwise arbitrate when idle or a hold ends
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        pick        = 1'b0;
        grant_fault = 1'b0;
        grant_done  = 1'b0;
        grant_node  = 1'b0;
        unique case (state)
            IDLE: pick = 1'b1;
            SHOW_FAULT: begin
                if (edge_fault) load = 1'b1;
                else            pick = zero_c;
            end
            SHOW_NODE_OK, SHOW_NODE_END: begin
                if (edge_fault) begin
                    state_next = SHOW_FAULT;
                    load       = 1'b1;
                end else begin
                    pick = zero_c;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (pick) begin
            if (pend_fault) begin
                state_next  = SHOW_FAULT;
                load        = 1'b1;
                grant_fault = 1'b1;
            end else if (pend_done) begin
                state_next = DONE;
                grant_done = 1'b1;
            end else if (pend_node) begin
                state_next = node_end ? SHOW_NODE_END : SHOW_NODE_OK;
                load       = 1'b1;
                grant_node = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // Colour of the upcoming cycle, mapped onto one LED's R/G/B pins
    always_comb begin
        colour = OFF;
        case (state_next)
            SHOW_FAULT:          colour = blink_next_c ? BLUE : OFF;
            SHOW_NODE_OK:        colour = RED;
            SHOW_NODE_END, DONE: colour = GREEN;
            default:             colour = OFF;
        endcase
        rgb_c   = '0;
        rgb_c.r = (colour == RED);
        rgb_c.g = (colour == GREEN);
        rgb_c.b = (colour == BLUE);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            fault_q     <= 1'b0;
            node_flag_q <= 1'b0;
            run_done_q  <= 1'b0;
            pend_fault  <= 1'b0;
            pend_done   <= 1'b0;
            pend_node   <= 1'b0;
            node_q      <= '0;
            rgb_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            armed       <= 1'b1;
            fault_q     <= bus.fault_detect;
            node_flag_q <= bus.node_flag;
            run_done_q  <= bus.run_done;
            // A fault edge during a show is consumed there as preempt/restart
            pend_fault  <= (pend_fault | (edge_fault & (state == IDLE))) & ~grant_fault;
            pend_done   <= (pend_done | (edge_done & (state != DONE))) & ~grant_done;
            pend_node   <= (pend_node | (edge_node & (state != DONE))) & ~grant_node;
            if (edge_node && (state != DONE)) begin
                node_q <= bus.node;
            end
            rgb_q  <= rgb_c;
            busy_q <= (state_next != IDLE);
        end
    end

    assign bus.led1_R1 = rgb_q.r;
    assign bus.led1_G1 = rgb_q.g;
    assign bus.led1_B1 = rgb_q.b;
    assign bus.led2_R2 = rgb_q.r;
    assign bus.led2_G2 = rgb_q.g;
    assign bus.led2_B2 = rgb_q.b;
    assign bus.led3_R3 = rgb_q.r;
    assign bus.led3_G3 = rgb_q.g;
    assign bus.led3_B3 = rgb_q.b;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_led_status_sequencer.sv
// Bench for led_status_sequencer with short hold/blink times: vector table plus
// hand-written preempt, restart, reset and terminal-state sequences.
module tb_led_status_sequencer;

    localparam int unsigned HOLD = 20;
    localparam int unsigned HALF = 5;
    localparam logic [2:0]  C_OFF = 3'b000;
    localparam logic [2:0]  C_R   = 3'b100;
    localparam logic [2:0]  C_G   = 3'b010;
    localparam logic [2:0]  C_B   = 3'b001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_status_sequencer_if bus ();

    led_status_sequencer #(
        .HOLD_CYCLES (HOLD),
        .BLINK_HALF  (HALF),
        .END_NODE    (11)
    ) dut (
        .clk_50M (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic       f;
        logic       n;
        logic       d;
        logic [7:0] node;
        logic [2:0] rgb;
        logic       blink;
        string      nm;
    } vec_t;

    vec_t       vt[6];
    logic [9:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic logic [9:0] word(input logic [2:0] rgb, input logic busy);
        return {busy, rgb, rgb, rgb};
    endfunction

    function automatic logic [9:0] actual();
        return {bus.busy, bus.led1_R1, bus.led1_G1, bus.led1_B1,
                bus.led2_R2, bus.led2_G2, bus.led2_B2,
                bus.led3_R3, bus.led3_G3, bus.led3_B3};
    endfunction

    task automatic check(input string nm, input logic [9:0] exp);
        logic [9:0] act;
        act = actual();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: busy+leds got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected display: steady colour, or the blue blink starting lit
    task automatic push_show(input logic [2:0] rgb, input logic blink, input int n);
        for (int i = 0; i < n; i++) begin
            if (blink) exp_q.push_back(word((((i / HALF) % 2) == 0) ? C_B : C_OFF, 1'b1));
            else       exp_q.push_back(word(rgb, 1'b1));
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(word(C_OFF, 1'b0));
    endtask

    // Called at a negedge; raises the chosen inputs for one cycle
    task automatic pulse(input logic f, input logic n, input logic d, input logic [7:0] nd);
        bus.fault_detect = f;
        bus.node_flag    = n;
        bus.run_done     = d;
        bus.node         = nd;
        @(negedge clk);
        bus.fault_detect = 1'b0;
        bus.node_flag    = 1'b0;
        bus.run_done     = 1'b0;
    endtask

    // Waits for the display to start, then compares one queued word per cycle
    task automatic drain(input string nm);
        int waited;
        logic [9:0] exp;
        waited = 0;
        while (!bus.busy && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.busy) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: busy still 0 after %0d cycles, expected display start", nm, waited);
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check(nm, exp);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.fault_detect = 1'b0;
        bus.node_flag    = 1'b0;
        bus.run_done     = 1'b0;
        bus.node         = 8'd0;

        vt[0] = '{1'b0, 1'b1, 1'b0, 8'd4,   C_R,   1'b0, "node4_red"};
        vt[1] = '{1'b0, 1'b1, 1'b0, 8'd11,  C_G,   1'b0, "node11_green"};
        vt[2] = '{1'b0, 1'b1, 1'b0, 8'd255, C_G,   1'b0, "node255_green"};
        vt[3] = '{1'b0, 1'b1, 1'b0, 8'd10,  C_R,   1'b0, "node10_red"};
        vt[4] = '{1'b0, 1'b1, 1'b0, 8'd0,   C_R,   1'b0, "node0_red"};
        vt[5] = '{1'b1, 1'b0, 1'b0, 8'd0,   C_OFF, 1'b1, "fault_blink"};

        @(posedge clk);
        @(negedge clk);
        check("reset_state", word(C_OFF, 1'b0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", word(C_OFF, 1'b0));

        for (int i = 0; i < 6; i++) begin
            push_show(vt[i].rgb, vt[i].blink, HOLD);
            push_idle(1);
            pulse(vt[i].f, vt[i].n, vt[i].d, vt[i].node);
            drain(vt[i].nm);
            repeat (2) @(negedge clk);
        end

        // Fault and node together: fault first, node immediately after with no gap
        push_show(C_OFF, 1'b1, HOLD);
        push_show(C_R, 1'b0, HOLD);
        push_idle(2);
        pulse(1'b1, 1'b1, 1'b0, 8'd4);
        drain("fault_then_node");

        // Fault in cycle 8 of a red display preempts it; node is not resumed
        push_show(C_R, 1'b0, 7);
        pulse(1'b0, 1'b1, 1'b0, 8'd4);
        drain("preempt_red_head");
        bus.fault_detect = 1'b1;
        check("preempt_red_c8", word(C_R, 1'b1));
        @(negedge clk);
        bus.fault_detect = 1'b0;
        push_show(C_OFF, 1'b1, HOLD);
        push_idle(3);
        drain("preempt_blue");

        // Second fault during a fault display restarts hold and blink
        push_show(C_OFF, 1'b1, 7);
        pulse(1'b1, 1'b0, 1'b0, 8'd0);
        drain("restart_head");
        bus.fault_detect = 1'b1;
        check("restart_c8", word(C_OFF, 1'b1));
        @(negedge clk);
        bus.fault_detect = 1'b0;
        push_show(C_OFF, 1'b1, HOLD);
        push_idle(2);
        drain("restart_blue");

        // Reset mid-display clears at once; fault held through release is ignored
        push_show(C_OFF, 1'b1, 7);
        bus.fault_detect = 1'b1;
        @(negedge clk);
        drain("fault_level");
        rst_n = 1'b0;
        #1;
        check("async_reset", word(C_OFF, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("held_fault_ignored", word(C_OFF, 1'b0));
        end
        bus.fault_detect = 1'b0;
        repeat (2) @(negedge clk);

        // Simultaneous fault, node 3 and run_done: blue, then green forever
        push_show(C_OFF, 1'b1, HOLD);
        push_show(C_G, 1'b0, 30);
        pulse(1'b1, 1'b1, 1'b1, 8'd3);
        drain("simul_done");
        pulse(1'b0, 1'b1, 1'b0, 8'd4);
        pulse(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            check("done_terminal", word(C_G, 1'b1));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_status_sequencer.md
LED_STATUS_SEQUENCER -- requirements
Module: led_status_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, giving the display duration per event in clocks (1 s at 50 MHz).
REQ-002 SHALL have parameter BLINK_HALF, default 12_500_000, giving the half-period in clocks of the fault blink.
REQ-003 SHALL have parameter END_NODE, default 11, giving the node index at or above which a node event counts as terminal.
REQ-004 SHALL have ports: clk_50M  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports: fault_detect  in  1  fault event; one-cycle pulse or level, rising edge taken.
REQ-007 SHALL have ports: node_flag  in  1  node-reached event; rising edge taken.
REQ-008 SHALL have ports: node  in  8  node index, sampled on the cycle the node_flag edge is detected.
REQ-009 SHALL have ports: run_done  in  1  run-complete event; rising edge taken.
REQ-010 SHALL have ports: led1_R1/G1/B1, led2_R2/G2/B2, led3_R3/G3/B3  out  1 each  RGB LED drives, active-high.
REQ-011 SHALL have ports: busy  out  1  high while any event is being displayed.

Function
REQ-012 SHALL edge-detect each event input with a registered previous value; an edge sets that source's pending bit.
REQ-013 SHALL give each source (FAULT, DONE, NODE) one pending bit; a repeat edge while already pending is merged, not counted.
REQ-014 SHALL latch node into a 1-entry register on each node_flag edge; the latest value overwrites any earlier one.
REQ-015 SHALL implement FSM states IDLE, SHOW_FAULT, SHOW_NODE_OK, SHOW_NODE_END, DONE.
REQ-016 SHALL grant pending events from IDLE with fixed priority FAULT > DONE > NODE; grant clears that pending bit on the same edge.
REQ-017 SHALL enter SHOW_NODE_END when the latched node >= END_NODE, else SHOW_NODE_OK, using an unsigned 8-bit compare.
REQ-018 SHALL load a hold counter with HOLD_CYCLES-1 on entry to each SHOW state and decrement it every clock.
REQ-019 SHALL return the FSM to IDLE on the cycle after the counter reads 0, giving exactly HOLD_CYCLES display cycles.
REQ-020 SHALL, in SHOW_FAULT, drive all three blue LEDs, toggling every BLINK_HALF cycles and starting lit; all R and G SHALL be 0.
REQ-021 SHALL, in SHOW_NODE_OK, drive all three red LEDs steady.
REQ-022 SHALL, in SHOW_NODE_END, drive all three green LEDs steady.
REQ-023 SHALL, in IDLE, drive all LEDs 0.
REQ-024 SHALL let a fault edge during SHOW_NODE_* preempt it: move to SHOW_FAULT next cycle with counters reloaded; the node event is dropped.
REQ-025 SHALL let a fault edge during SHOW_FAULT restart the hold and blink counters.
REQ-026 SHALL, on a run_done grant, enter DONE with all green steady; DONE is terminal until reset and ignores all events.
REQ-027 SHALL grant the next pending event directly on the same edge that ends a display, with no idle gap cycle.
REQ-028 SHALL resolve simultaneous edges by setting all pending bits and granting by priority, serving the rest in later displays.
REQ-029 SHALL assert busy in every SHOW_* state and in DONE.
REQ-030 SHALL register all outputs, with no combinational path from inputs to LED pins.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear the FSM to IDLE, all pending bits, counters, node register, edge registers, busy and all LED outputs to 0.
REQ-032 SHALL let reset asserted mid-display abort it immediately; after release, no event is pending.
REQ-033 SHALL ignore an input held high across reset release (edge register reset to 0 is then set without a pending edge: sample inputs on the first cycle after release into the edge registers only).

Structure
REQ-034 SHALL place the FSM state enum, colour-code constants (OFF, RED, GREEN, BLUE) and the END_NODE default in shared package astro_led_pkg.
REQ-035 SHALL implement the hold/blink timing in one sub-module, led_timer: load, decrement, zero flag and blink toggle.
REQ-036 SHALL keep the colour-to-pin mapping in led_status_sequencer.

Verification (HOLD_CYCLES=20, BLINK_HALF=5)
REQ-037 SHALL check: node_flag pulse with node=4 -> red for exactly 20 cycles, then all LEDs 0 and busy 0.
REQ-038 SHALL check: node=11 -> green 20 cycles; node=255 -> green; node=10 -> red.
REQ-039 SHALL check: fault pulse -> blue pattern on,off,on,off (5 cycles each) over 20 cycles.
REQ-040 SHALL check: fault at cycle 8 of a red node display -> blue from the next cycle for a full 20 cycles, with no red afterwards.
REQ-041 SHALL check: fault, node=3 and run_done on the same cycle -> blue 20 cycles, then green steady forever; the node event is never shown.
REQ-042 SHALL check: rst_n low mid-fault display -> all outputs 0 at once; fault_detect held high through release -> no display.
